// File: rtl/clock_set_controller.sv
// rtl/clock_set_controller.sv - mode/time-set sequencer with button debounce for the digital clock
module clock_set_controller #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_TICKS   = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       btn_mode_n,
    input  logic       btn_inc_n,
    input  logic       sec_carry,
    input  logic       min_carry,
    output logic       sec_en,
    output logic       sec_clr,
    output logic       min_en,
    output logic       hour_en,
    output logic [1:0] tap_out,
    output logic       set_mode,
    output logic       blink
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10,
        SET_SEC  = 2'b11
    } state_t;

    // Bit 0 is the mode button, bit 1 the increment button.
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    db_level;
    logic [1:0]    press;
    logic [DW-1:0] db_cnt [2];

    logic mode_ev;
    logic inc_ev;

    state_t        state;
    state_t        state_next;
    logic [TW-1:0] to_cnt;
    logic [TW-1:0] to_next;
    logic          blink_next;
    logic          sec_en_next;
    logic          sec_clr_next;
    logic          min_en_next;
    logic          hour_en_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1     <= 2'b11;
            sync2     <= 2'b11;
            db_level  <= 2'b11;
            press     <= 2'b00;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            sync1 <= {btn_inc_n, btn_mode_n};
            sync2 <= sync1;
            press <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES)) begin
                    // Level flips here; a flip to low is the single press event.
                    db_cnt[i]   <= '0;
                    db_level[i] <= sync2[i];
                    press[i]    <= ~sync2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign mode_ev = press[0];
    assign inc_ev  = press[1];

    always_comb begin
        state_next   = state;
        to_next      = to_cnt;
        blink_next   = blink;
        sec_en_next  = 1'b0;
        sec_clr_next = 1'b0;
        min_en_next  = 1'b0;
        hour_en_next = 1'b0;
        case (state)
            RUN: begin
                sec_en_next  = tick_1hz;
                min_en_next  = tick_1hz & sec_carry;
                hour_en_next = tick_1hz & sec_carry & min_carry;
                blink_next   = 1'b0;
                to_next      = '0;
                if (mode_ev) begin
                    state_next = SET_HOUR;
                    blink_next = 1'b1;
                end
            end
            default: begin
                if (mode_ev) begin
                    state_next = (state == SET_SEC) ? RUN : state_t'(state + 2'd1);
                    blink_next = (state != SET_SEC);
                    to_next    = '0;
                end else begin
                    if (tick_1hz) begin
                        blink_next = ~blink;
                    end
                    if (inc_ev) begin
                        // A press always beats a coincident timeout tick.
                        to_next = '0;
                        case (state)
                            SET_HOUR: hour_en_next = 1'b1;
                            SET_MIN:  min_en_next  = 1'b1;
                            SET_SEC:  sec_clr_next = 1'b1;
                            default:  ;
                        endcase
                    end else if (tick_1hz) begin
                        if (to_cnt == TW'(TIMEOUT_TICKS - 1)) begin
                            state_next = RUN;
                            to_next    = '0;
                            blink_next = 1'b0;
                        end else begin
                            to_next = to_cnt + 1'b1;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= RUN;
            to_cnt   <= '0;
            blink    <= 1'b0;
            set_mode <= 1'b0;
            sec_en   <= 1'b0;
            sec_clr  <= 1'b0;
            min_en   <= 1'b0;
            hour_en  <= 1'b0;
        end else begin
            state    <= state_next;
            to_cnt   <= to_next;
            blink    <= blink_next;
            set_mode <= (state_next != RUN);
            sec_en   <= sec_en_next;
            sec_clr  <= sec_clr_next;
            min_en   <= min_en_next;
            hour_en  <= hour_en_next;
        end
    end

    assign tap_out = state;

endmodule
